field_inverter: RTL and testbench

- Computes the multiplicative inverse c = a^-1 (mod p) over GF(p), p = `F_Q, operand width `F_NBITS.
- Uses Fermat exponentiation: a^-1 = a^(p-2).
- Serves as the multiplicative counterpart to the additive-inverse (negate) unit and sits alongside the other field_* arithmetic units.
- Time-shares one internal field_multiplier instance and uses the same en/ready/ready_pulse handshake as the other field units.

---
 rtl/field_inverter_if.sv | 19 +
 rtl/field_inverter.sv | 147 ++++++++++++++
 tb/tb_field_inverter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/field_inverter_if.sv
// Request/response bundle for field_inverter: start strobe + operand in,
// idle flag, completion pulse and result out.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

interface field_inverter_if;
    logic                 en;
    logic [`F_NBITS-1:0]  a;
    logic                 ready;
    logic                 ready_pulse;
    logic [`F_NBITS-1:0]  c;

    modport master (output en, a, input ready, ready_pulse, c);
    modport slave  (input en, a, output ready, ready_pulse, c);
endinterface

// File: rtl/field_inverter.sv
// GF(p) multiplicative inverse via Fermat (a^(p-2)), left-to-right square-and-multiply
// over one time-shared single-cycle modular multiplier.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

// Modular multiplier, one cycle en-to-ready_pulse. Reduction folds the high half
// onto the low half, which relies on the modulus being 2^W-1.
module field_multiplier (
    input  logic                clk,
    input  logic                rstb,
    input  logic                en,
    input  logic [`F_NBITS-1:0] a,
    input  logic [`F_NBITS-1:0] b,
    output logic                ready_pulse,
    output logic [`F_NBITS-1:0] c
);
    localparam int W = `F_NBITS;
    localparam logic [W-1:0] Q = `F_Q;

    logic [2*W-1:0] prod;
    logic [W:0]     fold, fold2, red;

    always_comb begin
        prod  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        fold  = {1'b0, prod[W-1:0]} + {1'b0, prod[2*W-1:W]};
        fold2 = {1'b0, fold[W-1:0]} + {{W{1'b0}}, fold[W]};
        red   = (fold2 >= {1'b0, Q}) ? fold2 - {1'b0, Q} : fold2;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ready_pulse <= 1'b0;
            c           <= '0;
        end else begin
            ready_pulse <= en;
            if (en) c <= red[W-1:0];
        end
    end
endmodule

module field_inverter (
    input  logic             clk,
    input  logic             rstb,
    field_inverter_if.slave  bus
);
    localparam int W  = `F_NBITS;
    localparam int IW = $clog2(W);
    localparam logic [W-1:0] Q = `F_Q;
    localparam logic [W-1:0] E = Q - W'(2);

    function automatic int msb_of(input logic [W-1:0] v);
        int m;
        m = 0;
        for (int k = 0; k < W; k++) if (v[k]) m = k;
        return m;
    endfunction

    localparam int EMSB = msb_of(E);
    localparam logic [IW-1:0] I_START = IW'(EMSB - 1);

    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;
    state_t state, next_state;

    logic [W-1:0]  x, acc, c_q, mul_b, mul_c;
    logic [IW-1:0] idx;
    logic          issued, mul_en, mul_rdy, zero_in;

    field_multiplier u_mul (
        .clk         (clk),
        .rstb        (rstb),
        .en          (mul_en),
        .a           (acc),
        .b           (mul_b),
        .ready_pulse (mul_rdy),
        .c           (mul_c)
    );

    assign zero_in         = (bus.a == '0) || (bus.a == Q);
    assign bus.ready       = (state == IDLE);
    assign bus.ready_pulse = (state == DONE);
    assign bus.c           = c_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= IDLE;
        else       state <= next_state;
    end

    // One multiplier op per SQR/MUL visit: issue once, then wait for its pulse.
    always_comb begin
        next_state = state;
        mul_en     = 1'b0;
        mul_b      = acc;
        case (state)
            IDLE: if (bus.en) next_state = zero_in ? DONE : SQR;
            SQR: begin
                mul_en = !issued;
                if (mul_rdy) begin
                    if (E[idx])         next_state = MUL;
                    else if (idx == '0) next_state = DONE;
                    else                next_state = SQR;
                end
            end
            MUL: begin
                mul_en = !issued;
                mul_b  = x;
                if (mul_rdy) next_state = (idx == '0) ? DONE : SQR;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            x      <= '0;
            acc    <= '0;
            idx    <= '0;
            issued <= 1'b0;
            c_q    <= '0;
        end else begin
            case (state)
                IDLE: if (bus.en) begin
                    x      <= bus.a;
                    acc    <= bus.a;
                    idx    <= I_START;
                    issued <= 1'b0;
                    if (zero_in) c_q <= '0;
                end
                SQR, MUL: begin
                    if (mul_en) issued <= 1'b1;
                    if (mul_rdy) begin
                        acc    <= mul_c;
                        issued <= 1'b0;
                        if (next_state == DONE) c_q <= mul_c;
                        // A set exponent bit keeps idx for the following MUL.
                        if (idx != '0 && (state == MUL || !E[idx])) idx <= idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_field_inverter.sv
// Scoreboard bench for field_inverter: expected inverse (extended Euclid) and
// latency queued at acceptance, checked when ready_pulse appears.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

module tb_field_inverter;
    localparam int W = `F_NBITS;
    localparam logic [W-1:0] P = `F_Q;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    field_inverter_if bus();
    field_inverter dut (.clk(clk), .rstb(rstb), .bus(bus.slave));

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] c;
        int           cyc;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    exp_t         e;
    int           n_chk = 0, n_fail = 0, cyc = 0, n_accept = 0, n_pulse = 0;
    int           slow_lat;
    logic         prev_pulse = 1'b0;
    logic [W-1:0] c_prev = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] inv_ref(input logic [W-1:0] v);
        longint r0, r1, s0, s1, q, t;
        if (v % P == 0) return '0;
        r0 = longint'(v); r1 = longint'(P); s0 = 1; s1 = 0;
        while (r1 != 0) begin
            q = r0 / r1;
            t = r0 - q * r1; r0 = r1; r1 = t;
            t = s0 - q * s1; s0 = s1; s1 = t;
        end
        if (s0 < 0) s0 = s0 + longint'(P);
        return W'(s0);
    endfunction

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [127:0] t;
        t = 128'(x) * 128'(y);
        return W'(t % 128'(P));
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rstb) begin
            sb.delete();
            prev_pulse = 1'b0;
            c_prev     = '0;
        end else begin
            if (bus.ready_pulse) begin
                n_pulse++;
                chk("pulse_width", prev_pulse, 0);
                if (sb.size() == 0) chk("spurious_pulse", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("c_value", bus.c, e.c);
                    chk("latency", cyc - e.cyc, e.lat);
                    if (e.a % P != 0) chk("a_times_c", mulmod(e.a, bus.c), 1);
                end
                c_prev = bus.c;
            end else begin
                chk("c_hold", bus.c, c_prev);
            end
            if (bus.en && bus.ready) begin
                e.a   = bus.a;
                e.c   = inv_ref(bus.a);
                e.cyc = cyc;
                e.lat = (bus.a == '0 || bus.a == P) ? 1 : slow_lat;
                sb.push_back(e);
                n_accept++;
            end
            prev_pulse = bus.ready_pulse;
        end
    end

    task automatic start(input logic [W-1:0] v);
        int n0;
        n0 = n_accept;
        bus.en = 1'b1;
        bus.a  = v;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (n_accept != n0) break;
        end
        chk("accept_seen", n_accept != n0, 1);
        bus.en = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 2000; k++) begin
            if (sb.size() == 0 && bus.ready) break;
            @(posedge clk); #1;
        end
        chk("done_seen", sb.size() == 0 && bus.ready, 1);
    endtask

    initial begin
        logic [W-1:0] ex, v, two60;
        logic [63:0]  r;
        int           s, m, n0, p0;

        ex = P - W'(2);
        s = 0; m = 0;
        for (int k = 0; k < W; k++) if (ex[k]) begin s = k; m++; end
        slow_lat = (s + m - 1) * 2 + 1;

        bus.en = 1'b0;
        bus.a  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bus.ready, 1);
        chk("rst_pulse", bus.ready_pulse, 0);
        chk("rst_c", bus.c, 0);
        rstb = 1'b1;
        @(posedge clk); #1;

        // a=1: exact latency via scoreboard, then one-cycle pulse and ready
        start(1);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (bus.ready_pulse) break;
        end
        chk("t1_pulse", bus.ready_pulse, 1);
        chk("t1_c", bus.c, 1);
        @(negedge clk);
        chk("t1_pulse_off", bus.ready_pulse, 0);
        chk("t1_ready", bus.ready, 1);
        @(posedge clk); #1;

        two60 = W'(1) << 60;
        start(2);
        wait_done();
        chk("inv_2", bus.c, two60);
        start(P - W'(1));
        wait_done();
        chk("inv_pm1", bus.c, P - W'(1));

        // zero fast path: operand 0 and operand p
        for (int j = 0; j < 2; j++) begin
            start(j == 0 ? '0 : P);
            @(negedge clk);
            chk("zero_ready_low", bus.ready, 0);
            chk("zero_pulse", bus.ready_pulse, 1);
            chk("zero_c", bus.c, 0);
            @(negedge clk);
            chk("zero_ready_back", bus.ready, 1);
            chk("zero_pulse_off", bus.ready_pulse, 0);
            @(posedge clk); #1;
        end

        // busy rejection: en held with a=5 for the whole a=3 operation
        p0 = n_pulse;
        n0 = n_accept;
        bus.en = 1'b1;
        bus.a  = 3;
        @(posedge clk); #1;
        bus.a  = 5;
        for (int k = 0; k < 2000; k++) begin
            if (n_accept == n0 + 2) break;
            @(posedge clk); #1;
        end
        bus.en = 1'b0;
        chk("busy_accepts", n_accept - n0, 2);
        wait_done();
        chk("busy_pulses", n_pulse - p0, 2);
        chk("busy_inv5", bus.c, inv_ref(5));

        // reset mid-operation aborts silently
        start(7);
        repeat (120) @(posedge clk);
        #1;
        rstb = 1'b0;
        #1;
        chk("abort_c", bus.c, 0);
        chk("abort_ready", bus.ready, 1);
        chk("abort_pulse", bus.ready_pulse, 0);
        @(posedge clk); #1;
        rstb = 1'b1;
        p0 = n_pulse;
        repeat (300) @(posedge clk);
        #1;
        chk("abort_no_pulse", n_pulse - p0, 0);
        start(7);
        wait_done();
        chk("restart_inv7", bus.c, inv_ref(7));

        // back-to-back random operands
        for (int k = 0; k < 150; k++) begin
            r = {$urandom(), $urandom()};
            v = W'(r % 64'(P - W'(1))) + W'(1);
            start(v);
        end
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
